branch_predictor_gshare: RTL and testbench
==========================================

BRANCH_PREDICTOR_GSHARE -- requirements
Module: branch_predictor_gshare

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning address and statistics width.
REQ-002 SHALL have parameter IDX_W, default 8, meaning log2 of pattern-table entries.
REQ-003 SHALL have parameter CNT_W, default 2, meaning saturating-counter width (2..4).
REQ-004 SHALL have parameter HIST_W, default 8, meaning global-history width (1..IDX_W).
REQ-005 SHALL have parameter IDX_LSB, default 2, meaning lowest PC bit used for indexing.
REQ-006 SHALL have parameter GSHARE, default 1, meaning 1 = gshare index, 0 = bimodal index.
REQ-007 SHALL have port clk, input, 1, meaning the single clock.
REQ-008 SHALL have port rst_n, input, 1, meaning reset, synchronous, active-low.
REQ-009 SHALL have port fet_valid, input, 1, meaning fetcher requests a prediction this cycle.
REQ-010 SHALL have port fet_inst_addr, input, XLEN, meaning PC of the fetched branch.
REQ-011 SHALL have port bp_ready, output, 1, meaning table initialised and predictions valid.
REQ-012 SHALL have port bp_pred, output, 1, meaning predicted taken.
REQ-013 SHALL have port bp_ghr, output, HIST_W, meaning history snapshot used for this prediction; carried with the instruction.
REQ-014 SHALL have ports rob_bp_enable (1), rob_bp_inst_addr (XLEN), rob_bp_jump (1), rob_bp_correct (1), rob_bp_ghr (HIST_W), all inputs, meaning commit-time branch update with its fetch snapshot.
REQ-015 SHALL have ports bp_correct_cnt and bp_total_cnt, outputs, XLEN, meaning accuracy statistics.

Function
REQ-016 Fetch index SHALL be fet_inst_addr[IDX_LSB +: IDX_W] XOR zero-extended current GHR when GSHARE=1, else the PC field alone.
REQ-017 bp_pred SHALL be combinational: MSB of the indexed counter; bp_ghr SHALL equal current GHR; both are forced 0 while bp_ready=0.
REQ-018 When fet_valid and bp_ready, GHR SHALL shift left at the next edge with bp_pred entering bit 0 (speculative update).
REQ-019 Update index SHALL use rob_bp_inst_addr and rob_bp_ghr by the rule of REQ-016.
REQ-020 When rob_bp_enable and bp_ready, the indexed counter SHALL increment if rob_bp_jump, else decrement, saturating at 2^CNT_W-1 and 0.
REQ-021 When rob_bp_enable and not rob_bp_correct, GHR SHALL load {rob_bp_ghr[HIST_W-2:0], rob_bp_jump}, overriding any same-cycle fetch shift.
REQ-022 Same-cycle fetch and update of one entry: fetch SHALL see the pre-update value.
REQ-023 bp_total_cnt SHALL increment per accepted update and bp_correct_cnt per accepted update with rob_bp_correct=1; both wrap modulo 2^XLEN.
REQ-024 States: INIT then RUN; INIT writes one entry per cycle, entry i at cycle i, value 2^(CNT_W-1)-1 (weakly not-taken), index counter from 0 to 2^IDX_W-1, then RUN with bp_ready=1.
REQ-025 In INIT, fet_valid and rob_bp_enable SHALL be ignored; no GHR or statistics change.

Reset
REQ-026 rst_n=0 at an edge SHALL set state INIT, index counter 0, GHR 0, both statistics 0, bp_ready 0, including mid-INIT and mid-RUN.
REQ-027 With defaults, bp_ready SHALL rise exactly 256 cycles after the first edge with rst_n=1.

Structure
REQ-028 Default parameter values and the INIT/RUN state encoding SHALL live in the shared global parameters package.
REQ-029 A sub-module sat_counter (parameter CNT_W; inputs value, inc; output next) SHALL implement the saturation rule.

Verification
REQ-030 Reset then idle -> bp_ready 0 for 256 cycles, then 1; bp_pred 0 for every index.
REQ-031 GSHARE=0, PC 0x40 updated taken twice -> bp_pred 1 at PC 0x40; third and fourth taken updates -> counter holds at 3.
REQ-032 GHR 0x00, three fetches predicting 0, then mispredict update with rob_bp_ghr 0x05, jump 1 -> GHR 0x0B next cycle.
REQ-033 Same-cycle fetch and update at index 0x10 with counter 1 -> bp_pred 0 that cycle, 1 the next.
REQ-034 Ten updates, seven correct -> bp_total_cnt 10, bp_correct_cnt 7; rst_n=0 mid-RUN -> both 0 and INIT restarts.

Source files
------------

// File: rtl/branch_predictor_gshare_pkg.sv
// Shared defaults and state encoding for the gshare branch predictor.
package branch_predictor_gshare_pkg;

   localparam int DEF_XLEN    = 32;
   localparam int DEF_IDX_W   = 8;
   localparam int DEF_CNT_W   = 2;
   localparam int DEF_HIST_W  = 8;
   localparam int DEF_IDX_LSB = 2;
   localparam int DEF_GSHARE  = 1;

   // INIT sweeps the pattern table; RUN serves predictions and updates.
   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } bp_state_e;

endpackage

// File: rtl/branch_predictor_gshare_sat_counter.sv
// Saturating up/down counter step used for pattern-table updates.
module sat_counter #(
   parameter int CNT_W = 2
) (
   input  logic [CNT_W-1:0] value,
   input  logic             inc,
   output logic [CNT_W-1:0] next
);

   // Step toward taken or not-taken, holding at the rails.
   always_comb begin
      next = value;
      if (inc) begin
         if (value != '1) next = value + CNT_W'(1);
      end else begin
         if (value != '0) next = value - CNT_W'(1);
      end
   end

endmodule

// File: rtl/branch_predictor_gshare.sv
// Gshare / bimodal branch predictor with speculative global history,
// commit-time counter training and accuracy statistics.
module branch_predictor_gshare
   import branch_predictor_gshare_pkg::*;
#(
   parameter int XLEN    = DEF_XLEN,
   parameter int IDX_W   = DEF_IDX_W,
   parameter int CNT_W   = DEF_CNT_W,
   parameter int HIST_W  = DEF_HIST_W,
   parameter int IDX_LSB = DEF_IDX_LSB,
   parameter int GSHARE  = DEF_GSHARE
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              fet_valid,
   input  logic [XLEN-1:0]   fet_inst_addr,
   output logic              bp_ready,
   output logic              bp_pred,
   output logic [HIST_W-1:0] bp_ghr,
   input  logic              rob_bp_enable,
   input  logic [XLEN-1:0]   rob_bp_inst_addr,
   input  logic              rob_bp_jump,
   input  logic              rob_bp_correct,
   input  logic [HIST_W-1:0] rob_bp_ghr,
   output logic [XLEN-1:0]   bp_correct_cnt,
   output logic [XLEN-1:0]   bp_total_cnt
);

   localparam int              ENTRIES  = 1 << IDX_W;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((1 << (CNT_W - 1)) - 1);

   bp_state_e         state_q, state_d;
   logic [IDX_W-1:0]  init_idx_q, init_idx_d;
   logic [HIST_W-1:0] ghr_q, ghr_d;
   logic [XLEN-1:0]   total_q, total_d;
   logic [XLEN-1:0]   correct_q, correct_d;
   logic [CNT_W-1:0]  pht_q [ENTRIES];

   logic [IDX_W-1:0]  fet_idx, upd_idx;
   logic [CNT_W-1:0]  fet_cnt, upd_cnt, upd_next;
   logic              wr_en;
   logic [IDX_W-1:0]  wr_idx;
   logic [CNT_W-1:0]  wr_data;
   logic              unused_addr_bits;

   // Only the index field of each PC matters; fold the rest away.
   assign unused_addr_bits = ^{fet_inst_addr, rob_bp_inst_addr};

   generate
      if (GSHARE != 0) begin : g_gshare
         assign fet_idx = fet_inst_addr[IDX_LSB +: IDX_W] ^ IDX_W'(ghr_q);
         assign upd_idx = rob_bp_inst_addr[IDX_LSB +: IDX_W] ^ IDX_W'(rob_bp_ghr);
      end else begin : g_bimodal
         assign fet_idx = fet_inst_addr[IDX_LSB +: IDX_W];
         assign upd_idx = rob_bp_inst_addr[IDX_LSB +: IDX_W];
      end
   endgenerate

   // Both reads see the table as it stood before this edge's write.
   assign fet_cnt  = pht_q[fet_idx];
   assign upd_cnt  = pht_q[upd_idx];

   assign bp_ready       = (state_q == ST_RUN);
   assign bp_pred        = bp_ready & fet_cnt[CNT_W-1];
   assign bp_ghr         = bp_ready ? ghr_q : '0;
   assign bp_total_cnt   = total_q;
   assign bp_correct_cnt = correct_q;

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_sat (
      .value (upd_cnt),
      .inc   (rob_bp_jump),
      .next  (upd_next)
   );

   // Next-state: table sweep in INIT; training, history and statistics in RUN.
   always_comb begin
      state_d    = state_q;
      init_idx_d = init_idx_q;
      ghr_d      = ghr_q;
      total_d    = total_q;
      correct_d  = correct_q;
      wr_en      = 1'b0;
      wr_idx     = upd_idx;
      wr_data    = upd_next;
      case (state_q)
         ST_INIT: begin
            wr_en      = 1'b1;
            wr_idx     = init_idx_q;
            wr_data    = CNT_INIT;
            init_idx_d = init_idx_q + IDX_W'(1);
            if (&init_idx_q) state_d = ST_RUN;
         end
         ST_RUN: begin
            wr_en = rob_bp_enable;
            if (rob_bp_enable) begin
               total_d = total_q + XLEN'(1);
               if (rob_bp_correct) correct_d = correct_q + XLEN'(1);
            end
            // A mispredict repairs history from the fetch snapshot and wins
            // over any speculative shift in the same cycle.
            if (rob_bp_enable && !rob_bp_correct) begin
               ghr_d = HIST_W'({rob_bp_ghr, rob_bp_jump});
            end else if (fet_valid) begin
               ghr_d = HIST_W'({ghr_q, bp_pred});
            end
         end
         default: state_d = ST_INIT;
      endcase
   end

   // Control registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_INIT;
         init_idx_q <= '0;
         ghr_q      <= '0;
         total_q    <= '0;
         correct_q  <= '0;
      end else begin
         state_q    <= state_d;
         init_idx_q <= init_idx_d;
         ghr_q      <= ghr_d;
         total_q    <= total_d;
         correct_q  <= correct_d;
      end
   end

   // Pattern table write port; contents are rebuilt by the INIT sweep.
   always_ff @(posedge clk) begin
      if (rst_n && wr_en) pht_q[wr_idx] <= wr_data;
   end

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Self-checking bench for branch_predictor_gshare (default parameters).
module tb_branch_predictor_gshare;

   localparam int ENTRIES  = 256;
   localparam int CNT_MAX  = 3;
   localparam int CNT_HALF = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        fet_valid;
   logic [31:0] fet_inst_addr;
   logic        bp_ready;
   logic        bp_pred;
   logic [7:0]  bp_ghr;
   logic        rob_bp_enable;
   logic [31:0] rob_bp_inst_addr;
   logic        rob_bp_jump;
   logic        rob_bp_correct;
   logic [7:0]  rob_bp_ghr;
   logic [31:0] bp_correct_cnt;
   logic [31:0] bp_total_cnt;

   always #5 clk = ~clk;

   branch_predictor_gshare dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .fet_valid        (fet_valid),
      .fet_inst_addr    (fet_inst_addr),
      .bp_ready         (bp_ready),
      .bp_pred          (bp_pred),
      .bp_ghr           (bp_ghr),
      .rob_bp_enable    (rob_bp_enable),
      .rob_bp_inst_addr (rob_bp_inst_addr),
      .rob_bp_jump      (rob_bp_jump),
      .rob_bp_correct   (rob_bp_correct),
      .rob_bp_ghr       (rob_bp_ghr),
      .bp_correct_cnt   (bp_correct_cnt),
      .bp_total_cnt     (bp_total_cnt)
   );

   int tests  = 0;
   int failed = 0;
   bit checking = 0;

   // Behavioural model: counters as plain ints, history as an int.
   int          m_pht [ENTRIES];
   int          m_ghr;
   bit          m_ready;
   int          m_init;
   logic [31:0] m_total;
   logic [31:0] m_correct;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int m_index(input logic [31:0] pc, input int ghr);
      return int'((pc >> 2) & 32'hFF) ^ (ghr & 255);
   endfunction

   function automatic bit m_pred(input logic [31:0] pc);
      return m_ready && (m_pht[m_index(pc, m_ghr)] >= CNT_HALF);
   endfunction

   // Advance the model by one clock edge using the inputs present at that edge.
   task automatic model_step();
      bit p;
      int u;
      if (!rst_n) begin
         m_ready = 0; m_init = 0; m_ghr = 0; m_total = 0; m_correct = 0;
      end else if (!m_ready) begin
         m_init++;
         if (m_init == ENTRIES) begin
            m_ready = 1;
            foreach (m_pht[i]) m_pht[i] = CNT_HALF - 1;
         end
      end else begin
         p = m_pred(fet_inst_addr);
         if (rob_bp_enable) begin
            $display("[TB] update pc=%h jump=%0d correct=%0d ghr=%h", rob_bp_inst_addr,
                     rob_bp_jump, rob_bp_correct, rob_bp_ghr);
            u = m_index(rob_bp_inst_addr, int'(rob_bp_ghr));
            if (rob_bp_jump) begin
               if (m_pht[u] < CNT_MAX) m_pht[u]++;
            end else begin
               if (m_pht[u] > 0) m_pht[u]--;
            end
            m_total++;
            if (rob_bp_correct) m_correct++;
         end
         if (rob_bp_enable && !rob_bp_correct)
            m_ghr = ((int'(rob_bp_ghr) << 1) | int'(rob_bp_jump)) & 255;
         else if (fet_valid)
            m_ghr = ((m_ghr << 1) | int'(p)) & 255;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic set_upd(input logic en, input logic [31:0] pc, input logic j,
                          input logic c, input logic [7:0] g);
      rob_bp_enable = en; rob_bp_inst_addr = pc; rob_bp_jump = j;
      rob_bp_correct = c; rob_bp_ghr = g;
   endtask

   task automatic wait_ready(input string name);
      int n = 0;
      while (!bp_ready && n < 400) begin
         tick();
         n++;
      end
      chk(name, n, 256);
   endtask

   // Compare process: every cycle, DUT outputs against the model.
   always @(negedge clk) begin
      if (checking) begin
         chk("cyc_ready", bp_ready, m_ready);
         chk("cyc_pred", bp_pred, m_pred(fet_inst_addr));
         chk("cyc_ghr", bp_ghr, m_ready ? m_ghr : 0);
         chk("cyc_total", bp_total_cnt, m_total);
         chk("cyc_correct", bp_correct_cnt, m_correct);
      end
   end

   initial begin
      int nz;
      rst_n = 1'b0;
      fet_valid = 1'b0;
      fet_inst_addr = '0;
      set_upd(1'b0, 32'h0, 1'b0, 1'b0, 8'h00);
      tick();
      checking = 1;
      chk("rst_ready", bp_ready, 0);
      rst_n = 1'b1;
      wait_ready("init_cycles");

      // Idle table: every index predicts not-taken.
      nz = 0;
      for (int i = 0; i < ENTRIES; i++) begin
         fet_inst_addr = 32'(i) << 2;
         #1;
         if (bp_pred) nz++;
         tick();
      end
      chk("idle_pred_all0", nz, 0);

      // Training and saturation at PC 0x40 with history 0.
      set_upd(1'b1, 32'h40, 1'b1, 1'b1, 8'h00);
      tick(); tick();
      set_upd(1'b0, 32'h0, 1'b0, 1'b0, 8'h00);
      fet_inst_addr = 32'h40;
      #1 chk("taken2_pred", bp_pred, 1);
      set_upd(1'b1, 32'h40, 1'b1, 1'b1, 8'h00);
      tick(); tick();
      set_upd(1'b0, 32'h0, 1'b0, 1'b0, 8'h00);
      #1 chk("taken4_pred", bp_pred, 1);
      set_upd(1'b1, 32'h40, 1'b0, 1'b1, 8'h00);
      tick();
      #1 chk("sat_dec1_pred", bp_pred, 1);
      tick();
      set_upd(1'b0, 32'h0, 1'b0, 1'b0, 8'h00);
      #1 chk("sat_dec2_pred", bp_pred, 0);

      // Three not-taken fetches, then a mispredict repair with a same-cycle fetch.
      fet_valid = 1'b1;
      fet_inst_addr = 32'h100;
      tick(); tick(); tick();
      fet_valid = 1'b0;
      #1 chk("ghr_after_fetch0", bp_ghr, 8'h00);
      fet_valid = 1'b1;
      set_upd(1'b1, 32'h200, 1'b1, 1'b0, 8'h05);
      tick();
      fet_valid = 1'b0;
      set_upd(1'b0, 32'h0, 1'b0, 1'b0, 8'h00);
      #1 chk("ghr_mispredict", bp_ghr, 8'h0B);

      // Same-cycle fetch and update of index 0x10 (counter currently 1).
      fet_valid = 1'b1;
      fet_inst_addr = 32'h6C;
      set_upd(1'b1, 32'h40, 1'b1, 1'b1, 8'h00);
      #1 chk("same_cycle_pred", bp_pred, 0);
      tick();
      fet_valid = 1'b0;
      fet_inst_addr = 32'h18;
      set_upd(1'b0, 32'h0, 1'b0, 1'b0, 8'h00);
      #1 chk("ghr_after_same", bp_ghr, 8'h16);
      chk("next_cycle_pred", bp_pred, 1);

      // Statistics: ten updates, seven correct; then resets mid-RUN and mid-INIT.
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      wait_ready("reinit_cycles");
      for (int i = 0; i < 10; i++) begin
         set_upd(1'b1, $urandom, 1'($urandom_range(0, 1)), (i < 7), 8'($urandom_range(0, 255)));
         tick();
      end
      set_upd(1'b0, 32'h0, 1'b0, 1'b0, 8'h00);
      #1 chk("stat_total", bp_total_cnt, 10);
      chk("stat_correct", bp_correct_cnt, 7);
      rst_n = 1'b0;
      tick();
      chk("rst_run_total", bp_total_cnt, 0);
      chk("rst_run_correct", bp_correct_cnt, 0);
      chk("rst_run_ready", bp_ready, 0);
      rst_n = 1'b1;
      repeat (100) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      wait_ready("mid_init_restart");

      // Randomised traffic, including occasional resets and traffic during INIT.
      for (int i = 0; i < 3000; i++) begin
         rst_n = ($urandom_range(0, 999) != 0);
         fet_valid = 1'($urandom_range(0, 1));
         fet_inst_addr = ($urandom & 32'hFFFF_FC03) | (32'($urandom_range(0, 31)) << 2);
         set_upd(($urandom_range(0, 2) == 0),
                 ($urandom & 32'hFFFF_FC03) | (32'($urandom_range(0, 31)) << 2),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                 8'($urandom_range(0, 255)));
         tick();
      end
      rst_n = 1'b1;
      fet_valid = 1'b0;
      set_upd(1'b0, 32'h0, 1'b0, 1'b0, 8'h00);
      tick();
      checking = 0;
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
